conv3x3_row_engine: RTL and testbench

//  Downstream consumer of the 3-row line buffer. Takes one set of three zero-padded rows
//  (W+2 pixels each, D channels), slides a 3x3xD kernel across them and streams W signed

---
 rtl/conv3x3_row_engine.sv | 150 +++++++++++++++
 tb/tb_conv3x3_row_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_row_engine.sv
// 3x3xD convolution over one latched set of three zero-padded rows.
// Streams W signed results, one per cycle, through a 2-stage multiply / adder-tree pipeline.

module conv_tap_mul #(
  parameter int DATA_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [DATA_BITS-1:0]       pix,
  input  logic [DATA_BITS-1:0]       wt,
  output logic signed [2*DATA_BITS:0] prod
);
  localparam int PW = 2*DATA_BITS+1;

  // Pixel is unsigned, weight is two's complement: widen both to the product width first.
  logic signed [PW-1:0] px_ext, wt_ext;
  assign px_ext = $signed({{(PW-DATA_BITS){1'b0}}, pix});
  assign wt_ext = $signed({{(PW-DATA_BITS){wt[DATA_BITS-1]}}, wt});

  always_ff @(posedge clk or posedge reset)
    if (reset)   prod <= '0;
    else if (en) prod <= px_ext * wt_ext;
endmodule

module conv3x3_row_engine #(
  parameter int DATA_BITS = 8,
  parameter int D         = 1,
  parameter int W         = 12,
  parameter int ACC_BITS  = 21,
  parameter int RELU      = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [D*(W+2)*DATA_BITS-1:0]    row_top,
  input  logic [D*(W+2)*DATA_BITS-1:0]    row_mid,
  input  logic [D*(W+2)*DATA_BITS-1:0]    row_bot,
  input  logic [9*D*DATA_BITS-1:0]        weights,
  input  logic                            valid_i,
  output logic                            ready,
  output logic [ACC_BITS-1:0]             out_data,
  output logic                            out_valid,
  output logic [$clog2(W)-1:0]            out_col,
  output logic                            conv_done,
  output logic                            overrun
);
  localparam int PW     = 2*DATA_BITS+1;
  localparam int NT     = 9*D;
  localparam int STAGES = 2;
  localparam int CW     = $clog2(W);
  localparam int XW     = $clog2(W+2);

  typedef logic [W+1:0][D-1:0][DATA_BITS-1:0] row_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                              state;
  row_t [2:0]                          rows_q;
  logic [8:0][D-1:0][DATA_BITS-1:0]    wts_q;
  logic [CW-1:0]                       col, col_s1;
  logic                                drain_last;
  logic [STAGES:0]                     vld_pipe;
  logic [NT-1:0][PW-1:0]               prods;
  logic signed [ACC_BITS-1:0]          sum;

  // vld_pipe[0] tracks RUN (a column is issued); higher bits follow the pipeline stages.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      overrun    <= 1'b0;
      col        <= '0;
      drain_last <= 1'b0;
      vld_pipe   <= '0;
      rows_q     <= '0;
      wts_q      <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      case (state)
        IDLE: if (valid_i) begin
          rows_q[0]   <= row_top;
          rows_q[1]   <= row_mid;
          rows_q[2]   <= row_bot;
          wts_q       <= weights;
          col         <= '0;
          vld_pipe[0] <= 1'b1;
          ready       <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          if (valid_i) overrun <= 1'b1;
          if (col == CW'(W-1)) begin
            vld_pipe[0] <= 1'b0;
            drain_last  <= 1'b0;
            state       <= DRAIN;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          if (valid_i) overrun <= 1'b1;
          if (drain_last) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            drain_last <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      for (genvar ch = 0; ch < D; ch++) begin : g_ch
        conv_tap_mul #(.DATA_BITS(DATA_BITS)) u_tap (
          .clk   (clk),
          .reset (reset),
          .en    (vld_pipe[0]),
          .pix   (rows_q[r][XW'(col) + XW'(c)][ch]),
          .wt    (wts_q[r*3+c][ch]),
          .prod  (prods[(r*3+c)*D+ch])
        );
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NT; i++)
      sum = sum + $signed({{(ACC_BITS-PW){prods[i][PW-1]}}, prods[i]});
  end

  // Output registers hold their last value between streams.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col_s1    <= '0;
      out_col   <= '0;
      out_data  <= '0;
      conv_done <= 1'b0;
    end else begin
      if (vld_pipe[0]) col_s1 <= col;
      if (vld_pipe[1]) begin
        out_col  <= col_s1;
        out_data <= (RELU != 0 && sum[ACC_BITS-1]) ? '0 : sum;
      end
      conv_done <= vld_pipe[1] && (col_s1 == CW'(W-1));
    end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_conv3x3_row_engine.sv
// Randomized + directed bench for conv3x3_row_engine; RELU=0 and RELU=1 instances share stimulus
// and are scored against a plain-arithmetic convolution model.

module tb_conv3x3_row_engine;
  localparam int DB = 8, D = 1, W = 12, AB = 21, CW = $clog2(W);

  logic clk = 1'b0;
  logic reset, valid_i;
  logic [D*(W+2)*DB-1:0] row_top, row_mid, row_bot;
  logic [9*D*DB-1:0]     weights;
  logic          ready0, ready1, out_valid0, out_valid1, conv_done0, conv_done1, overrun0, overrun1;
  logic [AB-1:0] out_data0, out_data1;
  logic [CW-1:0] out_col0, out_col1;

  always #5 clk = ~clk;

  conv3x3_row_engine #(.DATA_BITS(DB), .D(D), .W(W), .ACC_BITS(AB), .RELU(0)) dut (
    .clk(clk), .reset(reset), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .weights(weights), .valid_i(valid_i), .ready(ready0), .out_data(out_data0),
    .out_valid(out_valid0), .out_col(out_col0), .conv_done(conv_done0), .overrun(overrun0));

  conv3x3_row_engine #(.DATA_BITS(DB), .D(D), .W(W), .ACC_BITS(AB), .RELU(1)) dut_r (
    .clk(clk), .reset(reset), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .weights(weights), .valid_i(valid_i), .ready(ready1), .out_data(out_data1),
    .out_valid(out_valid1), .out_col(out_col1), .conv_done(conv_done1), .overrun(overrun1));

  typedef struct { int col; int data; } exp_t;
  exp_t q0[$], q1[$];
  int   px[3][W+2][D];
  int   wt[9][D];
  int   got0[W], got1[W];
  int   n_chk = 0, n_bad = 0;
  int   done_cnt = 0, res_cnt = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: direct 3x3xD dot product over padded columns col..col+2.
  function automatic int ref_px(input int col, input bit relu);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int ch = 0; ch < D; ch++)
          s += px[r][col+c][ch] * wt[r*3+c][ch];
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic mon_step(input int which, input logic v, input logic [AB-1:0] d,
                          input logic [CW-1:0] col, input logic done);
    exp_t e;
    if (v) begin
      chk($sformatf("q_nonempty%0d", which), (which == 0) ? int'(q0.size() > 0) : int'(q1.size() > 0), 1);
      if ((which == 0 && q0.size() > 0) || (which == 1 && q1.size() > 0)) begin
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("data%0d_c%0d", which, e.col), $signed(d), e.data);
        chk($sformatf("col%0d", which), col, e.col);
        chk($sformatf("done%0d_c%0d", which, e.col), done, (e.col == W-1) ? 1 : 0);
        if (col < W) begin
          if (which == 0) got0[col] = int'($signed(d));
          else            got1[col] = int'($signed(d));
        end
        if (which == 0) res_cnt++;
      end
    end else begin
      chk($sformatf("done_idle%0d", which), done, 0);
    end
    if (which == 0 && done) done_cnt++;
  endtask

  always @(negedge clk) if (!reset) begin
    mon_step(0, out_valid0, out_data0, out_col0, conv_done0);
    mon_step(1, out_valid1, out_data1, out_col1, conv_done1);
  end

  task automatic clear_set();
    for (int r = 0; r < 3; r++) for (int p = 0; p < W+2; p++) for (int ch = 0; ch < D; ch++) px[r][p][ch] = 0;
    for (int t = 0; t < 9; t++) for (int ch = 0; ch < D; ch++) wt[t][ch] = 0;
    for (int c = 0; c < W; c++) begin got0[c] = 12345678; got1[c] = 12345678; end
  endtask

  task automatic rand_set();
    clear_set();
    for (int r = 0; r < 3; r++) for (int p = 1; p <= W; p++) for (int ch = 0; ch < D; ch++)
      px[r][p][ch] = int'($urandom_range(0, 255));
    for (int t = 0; t < 9; t++) for (int ch = 0; ch < D; ch++)
      wt[t][ch] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic pack();
    for (int p = 0; p < W+2; p++) for (int ch = 0; ch < D; ch++) begin
      row_top[(p*D+ch)*DB +: DB] = px[0][p][ch][DB-1:0];
      row_mid[(p*D+ch)*DB +: DB] = px[1][p][ch][DB-1:0];
      row_bot[(p*D+ch)*DB +: DB] = px[2][p][ch][DB-1:0];
    end
    for (int t = 0; t < 9; t++) for (int ch = 0; ch < D; ch++)
      weights[(t*D+ch)*DB +: DB] = wt[t][ch][DB-1:0];
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_set();
    exp_t e;
    int n = 0;
    while (!ready0 && n < 40) begin @(negedge clk); n++; end
    chk("ready_before_send", ready0, 1);
    chk("ready_r_before_send", ready1, 1);
    pack();
    valid_i = 1'b1;
    for (int c = 0; c < W; c++) begin
      e.col = c;
      e.data = ref_px(c, 0); q0.push_back(e);
      e.data = ref_px(c, 1); q1.push_back(e);
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && ready0) break;
      @(negedge clk);
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  initial begin
    int dc, rc, found;
    reset = 1'b1; valid_i = 1'b0;
    row_top = '0; row_mid = '0; row_bot = '0; weights = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_col", out_col0, 0);
    chk("rst_conv_done", conv_done0, 0);
    chk("rst_overrun", overrun0, 0);
    chk("rst_ready", ready0, 1);
    reset = 1'b0;
    @(negedge clk);

    // 1: identity kernel, mid row 1..12, latency and single conv_done
    clear_set();
    for (int p = 1; p <= W; p++) px[1][p][0] = p;
    wt[4][0] = 1;
    dc = done_cnt;
    send_set();
    chk("lat_after_k", out_valid0, 0);
    @(negedge clk); chk("lat_after_k1", out_valid0, 0);
    @(negedge clk); chk("lat_after_k2", out_valid0, 1); chk("lat_col0", out_col0, 0);
    wait_drain();
    chk("t1_done_pulses", done_cnt - dc, 1);
    chk("t1_last", got0[W-1], 12);

    // 2: all-ones kernel, saturated pixels
    clear_set();
    for (int r = 0; r < 3; r++) for (int p = 1; p <= W; p++) px[r][p][0] = 255;
    for (int t = 0; t < 9; t++) wt[t][0] = 1;
    send_set(); wait_drain();
    chk("t2_col0", got0[0], 1530);
    chk("t2_col5", got0[5], 2295);
    chk("t2_col11", got0[W-1], 1530);

    // 3: most negative weights, with and without RELU
    for (int t = 0; t < 9; t++) wt[t][0] = -128;
    for (int c = 0; c < W; c++) begin got0[c] = 12345678; got1[c] = 12345678; end
    send_set(); wait_drain();
    chk("t3_edge", got0[0], -195840);
    chk("t3_interior", got0[5], -293760);
    for (int c = 0; c < W; c++) chk($sformatf("t3_relu_c%0d", c), got1[c], 0);

    // 5: three back-to-back row sets
    dc = done_cnt; rc = res_cnt;
    for (int s = 0; s < 3; s++) begin rand_set(); send_set(); end
    wait_drain();
    chk("t5_results", res_cnt - rc, 3*W);
    chk("t5_done_pulses", done_cnt - dc, 3);
    chk("t5_no_overrun", overrun0, 0);

    // 4: valid_i during RUN
    rc = res_cnt;
    rand_set(); send_set();
    repeat (3) @(negedge clk);
    valid_i = 1'b1; row_mid = ~row_mid; weights = ~weights;
    chk("t4_ready_run", ready0, 0);
    @(negedge clk);
    valid_i = 1'b0;
    chk("t4_overrun", overrun0, 1);
    chk("t4_overrun_r", overrun1, 1);
    wait_drain();
    chk("t4_results", res_cnt - rc, W);
    chk("t4_overrun_sticky", overrun0, 1);

    // 6: reset mid-row, then a clean row set
    rand_set(); send_set();
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid0 && out_col0 == 5) begin found = 1; break; end
    end
    chk("t6_saw_col5", found, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid0, 0);
    chk("t6_rst_data", out_data0, 0);
    chk("t6_rst_col", out_col0, 0);
    chk("t6_rst_done", conv_done0, 0);
    chk("t6_rst_overrun", overrun0, 0);
    chk("t6_rst_ready", ready0, 1);
    q0.delete(); q1.delete();
    dc = done_cnt;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_no_done", done_cnt - dc, 0);
    rc = res_cnt;
    rand_set(); send_set(); wait_drain();
    chk("t6_results", res_cnt - rc, W);

    // random back-to-back traffic
    dc = done_cnt; rc = res_cnt;
    for (int s = 0; s < 6; s++) begin rand_set(); send_set(); end
    wait_drain();
    chk("rand_results", res_cnt - rc, 6*W);
    chk("rand_done_pulses", done_cnt - dc, 6);
    chk("rand_no_overrun", overrun0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
